// File: rtl/clk_div_pkg.sv
// Shared constants, channel configuration layout and width helper for the multi-channel divider.
package clk_div_pkg;

    localparam int DEF_CNT_W = 28;
    localparam int DEF_DIV   = 2;
    localparam int DEF_HIGH  = 1;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] div;
        logic [DEF_CNT_W-1:0] high;
    } chan_cfg_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, active/shadow config and pending flag.
// Outputs are registered one cycle after the count they are derived from.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_DIV  = DEF_DIV,
    parameter int DEFAULT_HIGH = DEF_HIGH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    input  logic [CNT_W-1:0] wr_high_i,
    output logic             pend_o,
    output logic             clk_o,
    output logic             tick_o
);

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
    } cfg_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    cfg_t             act_q, act_d;
    cfg_t             shd_q, shd_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             stopped;
    logic             boundary;
    logic             apply;

    always_comb begin
        stopped  = (act_q.div == '0);
        // A stopped channel sits on a period boundary every cycle, so a new divisor can land.
        boundary = stopped || (cnt_q >= act_q.div - ONE);
        apply    = pend_q && (boundary || !en_i || sync_i);

        clk_d  = en_i && !stopped && (cnt_q < act_q.high);
        tick_d = en_i && !stopped && (act_q.high != '0) && (cnt_q == '0);
        cnt_d  = (sync_i || !en_i || boundary) ? '0 : cnt_q + ONE;

        act_d  = apply ? shd_q : act_q;
        shd_d  = shd_q;
        pend_d = pend_q && !apply;
        if (wr_i) begin
            shd_d  = '{div: wr_div_i, high: wr_high_i};
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_q  <= '{div: CNT_W'(DEFAULT_DIV), high: CNT_W'(DEFAULT_HIGH)};
            shd_q  <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign pend_o = pend_q;
    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider with per-channel tick strobes.
// Config writes stall (READY low) while the target channel still holds an unapplied update.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_DIV  = DEF_DIV,
    parameter int DEFAULT_HIGH = DEF_HIGH
) (
    input  logic                            CLK_IN,
    input  logic                            RST_IN,
    input  logic [NUM_CH-1:0]               EN_IN,
    input  logic                            SYNC_IN,
    input  logic                            CFG_VALID_IN,
    output logic                            CFG_READY_OUT,
    input  logic [clog2_min1(NUM_CH)-1:0]   CFG_CH_IN,
    input  logic [CNT_W-1:0]                CFG_DIV_IN,
    input  logic [CNT_W-1:0]                CFG_HIGH_IN,
    output logic [NUM_CH-1:0]               CLK_OUT,
    output logic [NUM_CH-1:0]               TICK_OUT
);

    localparam int CH_W = clog2_min1(NUM_CH);

    logic [NUM_CH-1:0]      pend;
    logic [NUM_CH-1:0]      wr;
    logic [(1<<CH_W)-1:0]   pend_pad;
    logic                   accept;

    // Unpopulated channel indices read as never pending; writes to them match no channel.
    always_comb begin
        pend_pad               = '0;
        pend_pad[NUM_CH-1:0]   = pend;
    end

    assign CFG_READY_OUT = !pend_pad[CFG_CH_IN];
    assign accept        = CFG_VALID_IN && CFG_READY_OUT;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign wr[gi] = accept && (CFG_CH_IN == CH_W'(gi));

        clk_div_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_HIGH (DEFAULT_HIGH)
        ) u_chan (
            .clk_i     (CLK_IN),
            .rst_i     (RST_IN),
            .en_i      (EN_IN[gi]),
            .sync_i    (SYNC_IN),
            .wr_i      (wr[gi]),
            .wr_div_i  (CFG_DIV_IN),
            .wr_high_i (CFG_HIGH_IN),
            .pend_o    (pend[gi]),
            .clk_o     (CLK_OUT[gi]),
            .tick_o    (TICK_OUT[gi])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed and randomized bench for clk_div_multi against a cycle-level phase model.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int CW  = 28;

    logic            CLK_IN = 1'b0;
    logic            RST_IN;
    logic [NCH-1:0]  EN_IN;
    logic            SYNC_IN;
    logic            CFG_VALID_IN;
    logic            CFG_READY_OUT;
    logic [1:0]      CFG_CH_IN;
    logic [CW-1:0]   CFG_DIV_IN;
    logic [CW-1:0]   CFG_HIGH_IN;
    logic [NCH-1:0]  CLK_OUT;
    logic [NCH-1:0]  TICK_OUT;

    clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(2), .DEFAULT_HIGH(1)) dut (
        .CLK_IN        (CLK_IN),
        .RST_IN        (RST_IN),
        .EN_IN         (EN_IN),
        .SYNC_IN       (SYNC_IN),
        .CFG_VALID_IN  (CFG_VALID_IN),
        .CFG_READY_OUT (CFG_READY_OUT),
        .CFG_CH_IN     (CFG_CH_IN),
        .CFG_DIV_IN    (CFG_DIV_IN),
        .CFG_HIGH_IN   (CFG_HIGH_IN),
        .CLK_OUT       (CLK_OUT),
        .TICK_OUT      (TICK_OUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: phase within the current period plus active/shadow config per channel.
    int             m_div[NCH];
    int             m_high[NCH];
    int             m_sdiv[NCH];
    int             m_shigh[NCH];
    int             m_ph[NCH];
    bit             m_pend[NCH];
    logic [NCH-1:0] m_clk;
    logic [NCH-1:0] m_tick;
    logic           last_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit pend_old[NCH];
        bit en, bound, restart;
        if (RST_IN) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = 2; m_high[c] = 1; m_sdiv[c] = 0; m_shigh[c] = 0;
                m_ph[c] = 0; m_pend[c] = 0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) pend_old[c] = m_pend[c];
            for (int c = 0; c < NCH; c++) begin
                en      = EN_IN[c];
                bound   = (m_div[c] == 0) || (m_ph[c] + 1 >= m_div[c]);
                m_clk[c]  = en && (m_div[c] != 0) && (m_ph[c] < m_high[c]);
                m_tick[c] = en && (m_div[c] != 0) && (m_high[c] != 0) && (m_ph[c] == 0);
                restart = SYNC_IN || !en || bound;
                if (m_pend[c] && restart) begin
                    m_div[c]  = m_sdiv[c];
                    m_high[c] = m_shigh[c];
                    m_pend[c] = 0;
                end
                m_ph[c] = restart ? 0 : m_ph[c] + 1;
                if (CFG_VALID_IN && !pend_old[CFG_CH_IN] && (int'(CFG_CH_IN) == c)) begin
                    m_sdiv[c]  = int'(CFG_DIV_IN);
                    m_shigh[c] = int'(CFG_HIGH_IN);
                    m_pend[c]  = 1;
                end
            end
        end
    endtask

    task automatic step();
        #1;
        last_rdy = CFG_READY_OUT;
        if (!RST_IN) check("cfg_ready", CFG_READY_OUT, !m_pend[CFG_CH_IN]);
        @(posedge CLK_IN);
        model_edge();
        #1;
        check("clk_out", CLK_OUT, m_clk);
        check("tick_out", TICK_OUT, m_tick);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input int ch, input int dv, input int hi, output bit saw_stall);
        bit acc;
        bit acc_now;
        CFG_CH_IN    = 2'(ch);
        CFG_DIV_IN   = CW'(dv);
        CFG_HIGH_IN  = CW'(hi);
        CFG_VALID_IN = 1'b1;
        saw_stall = 0;
        acc = 0;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc_now = !m_pend[ch];
            step();
            if (last_rdy !== 1'b1) saw_stall = 1;
            acc = acc_now;
        end
        CFG_VALID_IN = 1'b0;
        if (!acc) check("write_accept", 32'(acc), 32'd1);
    endtask

    initial begin
        bit stall;
        for (int c = 0; c < NCH; c++) begin
            m_div[c] = 2; m_high[c] = 1; m_sdiv[c] = 0; m_shigh[c] = 0;
            m_ph[c] = 0; m_pend[c] = 0;
        end
        m_clk = '0; m_tick = '0;
        RST_IN = 1'b1; EN_IN = '0; SYNC_IN = 1'b0; CFG_VALID_IN = 1'b0;
        CFG_CH_IN = '0; CFG_DIV_IN = '0; CFG_HIGH_IN = '0;

        // Reset state
        run(2);
        RST_IN = 1'b0;
        step();
        check("ready_after_reset", CFG_READY_OUT, 1'b1);

        // Default divide-by-two on all channels
        EN_IN = '1;
        run(8);

        // ch1 -> DIV=5 HIGH=2
        do_write(1, 5, 2, stall);
        run(20);

        // Back-to-back writes to ch0: second must stall until the first lands
        do_write(0, 10, 5, stall);
        do_write(0, 3, 2, stall);
        check("ch0_second_write_stalled", 32'(stall), 32'd1);
        run(25);

        // ch2 stopped, then divide-by-one
        do_write(2, 0, 3, stall);
        run(8);
        check("ch2_stopped_clk", CLK_OUT[2], 1'b0);
        do_write(2, 1, 1, stall);
        run(6);
        check("ch2_div1_clk", CLK_OUT[2], 1'b1);
        check("ch2_div1_tick", TICK_OUT[2], 1'b1);

        // SYNC realigns ch0 (DIV=4) and ch1 (DIV=6)
        do_write(0, 4, 2, stall);
        do_write(1, 6, 3, stall);
        run(9);
        SYNC_IN = 1'b1;
        step();
        SYNC_IN = 1'b0;
        step();
        check("sync_clk_pair", CLK_OUT[1:0], 2'b11);
        check("sync_tick_pair", TICK_OUT[1:0], 2'b11);
        run(11);
        step();
        check("recoincide_tick_pair", TICK_OUT[1:0], 2'b11);
        run(5);

        // Drop EN[3] with a write pending
        do_write(3, 7, 3, stall);
        EN_IN[3] = 1'b0;
        step();
        check("ch3_disabled_clk", CLK_OUT[3], 1'b0);
        CFG_CH_IN = 2'd3;
        step();
        check("ch3_pending_cleared", CFG_READY_OUT, 1'b1);
        EN_IN[3] = 1'b1;
        run(16);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) EN_IN[c] = ($urandom_range(7) != 0);
            SYNC_IN      = ($urandom_range(39) == 0);
            CFG_VALID_IN = ($urandom_range(3) == 0);
            CFG_CH_IN    = 2'($urandom_range(3));
            CFG_DIV_IN   = CW'($urandom_range(9));
            CFG_HIGH_IN  = CW'($urandom_range(10));
            step();
        end
        SYNC_IN = 1'b0; CFG_VALID_IN = 1'b0; EN_IN = '1;
        run(10);

        // Reset mid-period restores defaults
        RST_IN = 1'b1;
        step();
        check("reset_clk_zero", CLK_OUT, 4'b0000);
        check("reset_tick_zero", TICK_OUT, 4'b0000);
        RST_IN = 1'b0;
        run(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
